stage_bridge: RTL and testbench
===============================

STAGE_BRIDGE -- requirements
Module: stage_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of transferred word.
REQ-002 Parameter DEPTH, default 4, number of buffer entries; power of two, minimum 2.
REQ-003 Port clk  input  1  core clock; all logic is clocked on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port clk_en  input  1  stage-transfer strobe from the clock-enable generator; a pop may occur only when it is high.
REQ-006 Port flush  input  1  synchronous buffer clear.
REQ-007 Port in_valid  input  1  producer presents in_data.
REQ-008 Port in_data  input  DATA_WIDTH  producer word.
REQ-009 Port in_ready  output  1  buffer can accept a word this cycle.
REQ-010 Port stall  input  1  downstream stage refuses transfer.
REQ-011 Port out_valid  output  1  head entry present.
REQ-012 Port out_data  output  DATA_WIDTH  head entry word.
REQ-013 Port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 Port overrun  output  1  sticky flag: push attempted while full.

Function
REQ-015 Push occurs in a cycle when in_valid=1 and in_ready=1; the word is written at the tail and the tail pointer advances by 1 modulo DEPTH.
REQ-016 in_ready shall be 1 exactly when level < DEPTH; it depends only on registered state and never on clk_en, stall or in_valid.
REQ-017 Pop occurs in a cycle when clk_en=1, stall=0 and out_valid=1; the head pointer advances by 1 modulo DEPTH.
REQ-018 A cycle with clk_en=0 shall never pop, regardless of stall.
REQ-019 out_valid shall be 1 exactly when level != 0; out_data shall equal the head entry whenever out_valid=1 and is don't-care otherwise.
REQ-020 Latency: a word pushed in cycle N shall be visible on out_data/out_valid in cycle N+1 when the buffer was empty; there is no combinational in-to-out path.
REQ-021 out_data shall stay stable while out_valid=1 and no pop occurs.
REQ-022 Simultaneous push and pop: both take effect; level is unchanged.
REQ-023 Full with pop in the same cycle: in_ready is 0, so no push; level decrements by 1.
REQ-024 Pop request when empty (clk_en=1, stall=0, out_valid=0) shall have no effect.
REQ-025 level update: +1 on push-only, -1 on pop-only, unchanged otherwise; it never exceeds DEPTH or goes below 0.
REQ-026 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without any other side effect.
REQ-027 overrun shall be set in the cycle after in_valid=1 while level == DEPTH. It stays set until rst.
REQ-028 flush=1 shall clear both pointers and level in the next cycle. flush has priority over the push and pop in the same cycle, both of which are discarded. flush does not clear overrun.
REQ-029 Buffer storage contents are not reset; only pointers, level and overrun are.

Reset
REQ-030 When rst=1 at a clock edge, after that edge: level=0, out_valid=0, in_ready=1, overrun=0, both pointers 0.
REQ-031 rst has priority over flush, push and pop; words in flight or buffered at reset are lost.
REQ-032 Reset applied mid-operation shall behave identically to reset from power-up.

Verification
REQ-033 Fill: clk_en=0, push 0x11,0x22,0x33,0x44 -> level=4, in_ready=0, out_data=0x11, no pop occurs.
REQ-034 Drain under strobe (clk_en high 1 cycle in 3), stall=0 -> words leave in order 0x11..0x44, one per strobe, level reaches 0.
REQ-035 Full plus in_valid=1 and a strobe in the same cycle -> word not accepted, level 4->3, overrun=1 from the next cycle.
REQ-036 Steady stream with clk_en=1 and push every cycle -> level constant at 1, pointers wrap past DEPTH-1 with data intact over 16 words.
REQ-037 stall=1 across 3 strobes with level=2 -> no pop, out_data held; after stall drops, the next strobe pops.
REQ-038 flush with level=3 plus a simultaneous push -> level=0, out_valid=0 next cycle, overrun kept; rst mid-stream -> all REQ-030 values.

Source files
------------

// File: rtl/stage_bridge.sv
// Strobe-gated FIFO bridge between two pipeline stages. Pushes are free-running;
// pops happen only on a clk_en strobe while the downstream stage is not stalled.
module stage_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    input  logic                       stall,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         head_q, tail_q;
    logic [LW-1:0]         level_q;
    logic                  overrun_q;
    logic                  push, pop;

    // Flow control looks only at registered occupancy, never at the strobe.
    assign in_ready  = (level_q < FULL);
    assign out_valid = (level_q != '0);
    assign out_data  = mem[head_q];
    assign level     = level_q;
    assign overrun   = overrun_q;

    assign push = in_valid & in_ready;
    assign pop  = clk_en & ~stall & out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (in_valid && !in_ready)
                overrun_q <= 1'b1;
            // Flush discards any push/pop in the same cycle but leaves overrun alone.
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                level_q <= '0;
            end else begin
                if (push)
                    tail_q <= tail_q + PW'(1);
                if (pop)
                    head_q <= head_q + PW'(1);
                if (push && !pop)
                    level_q <= level_q + LW'(1);
                else if (pop && !push)
                    level_q <= level_q - LW'(1);
            end
        end
    end

    // Storage is deliberately left unreset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push)
            mem[tail_q] <= in_data;
    end

endmodule

// File: tb/tb_stage_bridge.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_stage_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, clk_en, flush, in_valid, stall;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, overrun;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;

    int n_cmp = 0;
    int n_bad = 0;
    bit active = 1'b0;

    stage_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall(stall), .out_valid(out_valid), .out_data(out_data),
        .level(level), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue plus a sticky bit.
    logic [DW-1:0] q[$];
    bit            m_ovr = 1'b0;

    always @(posedge clk) begin
        bit do_push, do_pop;
        if (rst) begin
            q.delete();
            m_ovr = 1'b0;
        end else begin
            if (in_valid && q.size() == DEPTH)
                m_ovr = 1'b1;
            if (flush) begin
                q.delete();
            end else begin
                do_push = in_valid && (q.size() < DEPTH);
                do_pop  = clk_en && !stall && (q.size() > 0);
                if (do_pop)
                    void'(q.pop_front());
                if (do_push)
                    q.push_back(in_data);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            check("model_level", 64'(level), 64'(q.size()));
            check("model_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            check("model_out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("model_overrun", 64'(overrun), 64'(m_ovr));
            if (q.size() != 0)
                check("model_out_data", 64'(out_data), 64'(q[0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        clk_en = 1'b1;
        cyc();
        clk_en = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; flush = 1'b0; in_valid = 1'b0; stall = 1'b0; in_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        active = 1'b1;
        check("reset_level", 64'(level), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_overrun", 64'(overrun), 64'd0);

        // Fill with clk_en low: nothing may leave.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'h11 * i;
            cyc();
        end
        in_valid = 1'b0;
        check("fill_level", 64'(level), 64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_head", 64'(out_data), 64'h11);
        cyc();
        check("fill_hold", 64'(level), 64'd4);

        // Drain at one strobe in three.
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 64'(out_data), 64'(32'h11 * i));
            strobe();
            check("drain_level", 64'(level), 64'(4 - i));
        end

        // Full + push + strobe together: pop only, overrun set.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'h11 * i;
            cyc();
        end
        in_valid = 1'b1; in_data = 32'h55; clk_en = 1'b1;
        cyc();
        in_valid = 1'b0; clk_en = 1'b0;
        check("full_pop_level", 64'(level), 64'd3);
        check("full_pop_overrun", 64'(overrun), 64'd1);
        check("full_pop_head", 64'(out_data), 64'h22);

        // Flush at level 3 with a simultaneous push.
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h66;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_level", 64'(level), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_overrun_kept", 64'(overrun), 64'd1);

        // Steady stream: level stays 1 and pointers wrap several times.
        clk_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 32'hA000_0000 + i;
            cyc();
            check("stream_level", 64'(level), 64'd1);
            check("stream_data", 64'(out_data), 64'(32'hA000_0000 + i));
        end
        in_valid = 1'b0;
        cyc();
        clk_en = 1'b0;
        check("stream_empty", 64'(level), 64'd0);

        // Stall across three strobes at level 2.
        in_valid = 1'b1; in_data = 32'hB1; cyc();
        in_data = 32'hB2; cyc();
        in_valid = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe();
            check("stall_level", 64'(level), 64'd2);
            check("stall_data", 64'(out_data), 64'hB1);
        end
        stall = 1'b0;
        strobe();
        check("unstall_level", 64'(level), 64'd1);
        check("unstall_data", 64'(out_data), 64'hB2);

        // Randomized traffic, with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom();
            clk_en   = ($urandom_range(0, 2) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 63) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0; clk_en = 1'b0;

        // Reset mid-stream after forcing an overrun.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 32'hC0 + i;
            cyc();
        end
        check("pre_rst_overrun", 64'(overrun), 64'd1);
        rst = 1'b1; in_valid = 1'b1; clk_en = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0; clk_en = 1'b0;
        check("midrst_level", 64'(level), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_overrun", 64'(overrun), 64'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
